mult_div_unit: RTL and testbench

Iterative, parametrised multiply/divide unit with architectural HI/LO registers for the MIPS CPU. It replaces the single-cycle combinational MULT/MULTU/DIV/DIVU paths in the ALU: shift-add multiplication and restoring division, one bit per cycle. The control unit stalls on `Busy`. The register-file write-back reads `Hi`/`Lo` for MFHI/MFLO, and MTHI/MTLO write them directly.

---
 rtl/mult_div_unit.sv | 167 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, followed by a sign-fixup cycle.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] Src1,
  input  logic [WIDTH-1:0] Src2,
  input  logic             HiWriteEn,
  input  logic             LoWriteEn,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e                state_q, state_d;
  logic                  is_div_q, is_div_d;
  logic                  neg_res_q, neg_res_d;
  logic                  neg_rem_q, neg_rem_d;
  logic                  dbz_q, dbz_d;
  logic [WIDTH-1:0]      mcand_q, mcand_d;
  logic [2*WIDTH:0]      acc_q, acc_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]      hi_q, hi_d;
  logic [WIDTH-1:0]      lo_q, lo_d;
  logic                  done_q, done_d;
  logic                  div0_q, div0_d;

  logic                  src1_neg, src2_neg;
  logic [WIDTH-1:0]      mag1, mag2;
  logic [WIDTH:0]        mul_sum;
  logic [WIDTH:0]        div_shift_rem;
  logic [WIDTH:0]        div_diff;
  logic [2*WIDTH-1:0]    prod, prod_fix;
  logic [WIDTH-1:0]      quot_fix, rem_fix;

  // Sign flags are only ever set for the signed ops (Op[0] == 0).
  assign src1_neg = ~Op[0] & Src1[WIDTH-1];
  assign src2_neg = ~Op[0] & Src2[WIDTH-1];
  assign mag1     = src1_neg ? -Src1 : Src1;
  assign mag2     = src2_neg ? -Src2 : Src2;

  assign mul_sum       = acc_q[2*WIDTH:WIDTH] + {1'b0, (acc_q[0] ? mcand_q : '0)};
  assign div_shift_rem = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff      = div_shift_rem - {1'b0, mcand_q};

  assign prod     = acc_q[2*WIDTH-1:0];
  assign prod_fix = neg_res_q ? -prod : prod;
  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign quot_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    div0_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (HiWriteEn) hi_d = WriteData;
        if (LoWriteEn) lo_d = WriteData;
        if (Start) begin
          is_div_d  = Op[1];
          neg_res_d = src1_neg ^ src2_neg;
          neg_rem_d = src1_neg;
          dbz_d     = Op[1] & (Src2 == '0);
          cnt_d     = CntW'(WIDTH - 1);
          state_d   = StRun;
          if (Op[1]) begin
            mcand_d = mag2;
            acc_d   = {{(WIDTH + 1){1'b0}}, mag1};
          end else begin
            mcand_d = mag1;
            acc_d   = {{(WIDTH + 1){1'b0}}, mag2};
          end
        end
      end

      StRun: begin
        if (is_div_q) begin
          if (!div_diff[WIDTH]) begin
            acc_d = {1'b0, div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {1'b0, div_shift_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == '0) state_d = StFix;
      end

      StFix: begin
        if (is_div_q) begin
          if (!dbz_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        div0_d  = is_div_q & dbz_q;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      div0_q    <= div0_d;
    end
  end

  assign Busy      = (state_q != StIdle);
  assign Done      = done_q;
  assign DivByZero = div0_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit at WIDTH=32 and WIDTH=8.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] Src1, Src2, WriteData;
  logic        HiWriteEn, LoWriteEn;
  logic        Busy, Done, DivByZero;
  logic [31:0] Hi, Lo;

  logic        s8_start;
  logic [1:0]  s8_op;
  logic [7:0]  s8_a, s8_b;
  logic        s8_busy, s8_done, s8_dbz;
  logic [7:0]  s8_hi, s8_lo;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .Op        (Op),
    .Src1      (Src1),
    .Src2      (Src2),
    .HiWriteEn (HiWriteEn),
    .LoWriteEn (LoWriteEn),
    .WriteData (WriteData),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero),
    .Hi        (Hi),
    .Lo        (Lo)
  );

  mult_div_unit #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .reset     (reset),
    .Start     (s8_start),
    .Op        (s8_op),
    .Src1      (s8_a),
    .Src2      (s8_b),
    .HiWriteEn (1'b0),
    .LoWriteEn (1'b0),
    .WriteData (8'h00),
    .Busy      (s8_busy),
    .Done      (s8_done),
    .DivByZero (s8_dbz),
    .Hi        (s8_hi),
    .Lo        (s8_lo)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; returns at the negedge where Done should be high.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit exp_dbz, input bit hazard);
    int busy_n;
    bit early_done;
    Start = 1'b1;
    Op    = op;
    Src1  = a;
    Src2  = b;
    @(negedge clk);
    Start = 1'b0;
    Op    = ~op;
    Src1  = $urandom;
    Src2  = $urandom;
    busy_n     = 0;
    early_done = 1'b0;
    while (Busy && busy_n < 100) begin
      busy_n++;
      if (Done) early_done = 1'b1;
      if (hazard) begin
        Start     = (busy_n == 5);
        LoWriteEn = (busy_n == 5) || (busy_n == 6);
        WriteData = 32'hAAAA;
      end
      @(negedge clk);
    end
    Start     = 1'b0;
    LoWriteEn = 1'b0;
    check_eq({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
    check_eq({tag, "_early_done"}, 64'(early_done), 64'd0);
    check_eq({tag, "_done"}, 64'(Done), 64'd1);
    check_eq({tag, "_dbz"}, 64'(DivByZero), 64'(exp_dbz));
  endtask

  initial begin
    int n;
    bit seen;
    reset = 1'b1; Start = 1'b0; Op = 2'b00; Src1 = '0; Src2 = '0;
    HiWriteEn = 1'b0; LoWriteEn = 1'b0; WriteData = '0;
    s8_start = 1'b0; s8_op = 2'b00; s8_a = '0; s8_b = '0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_busy", 64'(Busy), 64'd0);
    check_eq("rst_done", 64'(Done), 64'd0);
    check_eq("rst_dbz", 64'(DivByZero), 64'd0);
    check_eq("rst_hi", 64'(Hi), 64'd0);
    check_eq("rst_lo", 64'(Lo), 64'd0);
    reset = 1'b0;

    run_op("mult", 2'b00, 32'hFFFF_FFFF, 32'd7, 1'b0, 1'b0);
    check_eq("mult_hi", 64'(Hi), 64'hFFFF_FFFF);
    check_eq("mult_lo", 64'(Lo), 64'hFFFF_FFF9);
    @(negedge clk);
    check_eq("mult_done_clear", 64'(Done), 64'd0);

    run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check_eq("multu_hi", 64'(Hi), 64'hFFFF_FFFE);
    check_eq("multu_lo", 64'(Lo), 64'h0000_0001);
    @(negedge clk);

    run_op("div", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check_eq("div_lo", 64'(Lo), 64'hFFFF_FFFD);
    check_eq("div_hi", 64'(Hi), 64'hFFFF_FFFF);
    @(negedge clk);

    run_op("divu", 2'b11, 32'd7, 32'd2, 1'b0, 1'b0);
    check_eq("divu_lo", 64'(Lo), 64'd3);
    check_eq("divu_hi", 64'(Hi), 64'd1);
    @(negedge clk);

    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check_eq("div_ovf_lo", 64'(Lo), 64'h8000_0000);
    check_eq("div_ovf_hi", 64'(Hi), 64'd0);
    @(negedge clk);

    run_op("div_negdvsr", 2'b10, 32'd100, 32'hFFFF_FFF9, 1'b0, 1'b0);
    check_eq("div_negdvsr_lo", 64'(Lo), 64'hFFFF_FFF2);
    check_eq("div_negdvsr_hi", 64'(Hi), 64'd2);
    // Issued in the Done cycle of the previous operation.
    run_op("b2b_mult", 2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b0, 1'b0);
    check_eq("b2b_mult_hi", 64'(Hi), 64'd0);
    check_eq("b2b_mult_lo", 64'(Lo), 64'd15);
    @(negedge clk);

    HiWriteEn = 1'b1; WriteData = 32'h1234;
    @(negedge clk);
    HiWriteEn = 1'b0; LoWriteEn = 1'b1; WriteData = 32'h5678;
    @(negedge clk);
    LoWriteEn = 1'b0;
    check_eq("mthi", 64'(Hi), 64'h1234);
    check_eq("mtlo", 64'(Lo), 64'h5678);
    run_op("dbz", 2'b11, 32'd9, 32'd0, 1'b1, 1'b0);
    check_eq("dbz_hi_kept", 64'(Hi), 64'h1234);
    check_eq("dbz_lo_kept", 64'(Lo), 64'h5678);
    @(negedge clk);
    check_eq("dbz_flag_clear", 64'(DivByZero), 64'd0);
    check_eq("dbz_done_clear", 64'(Done), 64'd0);

    run_op("hazard", 2'b01, 32'd3, 32'd5, 1'b0, 1'b1);
    check_eq("hazard_hi", 64'(Hi), 64'd0);
    check_eq("hazard_lo", 64'(Lo), 64'd15);
    @(negedge clk);
    check_eq("hazard_no_restart", 64'(Busy), 64'd0);

    Start = 1'b1; Op = 2'b00; Src1 = 32'h10; Src2 = 32'h10;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("midrst_busy", 64'(Busy), 64'd0);
    check_eq("midrst_hi", 64'(Hi), 64'd0);
    check_eq("midrst_lo", 64'(Lo), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      if (Done) seen = 1'b1;
      @(negedge clk);
    end
    check_eq("midrst_no_done", 64'(seen), 64'd0);

    s8_start = 1'b1; s8_op = 2'b00; s8_a = 8'hFF; s8_b = 8'h02;
    @(negedge clk);
    s8_start = 1'b0; s8_a = 8'h5A; s8_b = 8'hA5;
    n = 0;
    while (s8_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check_eq("w8_busy_cycles", 64'(n), 64'd9);
    check_eq("w8_done", 64'(s8_done), 64'd1);
    check_eq("w8_hi", 64'(s8_hi), 64'hFF);
    check_eq("w8_lo", 64'(s8_lo), 64'hFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
